rptr_empty: RTL and testbench
=============================

RPTR_EMPTY -- requirements
Module: rptr_empty

Interface
REQ-001 Parameter ADDRSIZE, default 4, memory address width; FIFO depth is 2**ADDRSIZE; minimum 2.
REQ-002 Parameter AE_THRESH, default 2, almost-empty threshold in entries; range 0..2**ADDRSIZE.
REQ-003 rclk  input  1  read-domain clock; all state updates on rising edge.
REQ-004 rrst_n  input  1  reset, synchronous, active-low, sampled on rising rclk.
REQ-005 rinc  input  1  read request; one entry consumed per cycle when rinc=1 and rempty=0.
REQ-006 wptr  input  ADDRSIZE+1  write pointer, Gray-coded, from write clock domain (asynchronous).
REQ-007 rptr  output  ADDRSIZE+1  read pointer, Gray-coded, registered; sent to the write domain.
REQ-008 raddr  output  ADDRSIZE  memory read address, registered.
REQ-009 rempty  output  1  FIFO empty flag, registered.
REQ-010 ralmost_empty  output  1  level <= AE_THRESH, registered.
REQ-011 rlevel  output  ADDRSIZE+1  entries available to read, registered, range 0..2**ADDRSIZE.

Function
REQ-012 wptr SHALL pass through a two-flop synchronizer (rq1_wptr, rq2_wptr) clocked by rclk; only rq2_wptr is used by downstream logic.
REQ-013 Pointer SHALL be held as (ADDRSIZE+1)-bit Gray code; rbin = Gray-to-binary of rptr; rbnext = rbin + (rinc & ~rempty), modulo 2**(ADDRSIZE+1); rgnext = (rbnext>>1) ^ rbnext.
REQ-014 rptr SHALL load rgnext every rclk edge; a granted read advances rptr by exactly one Gray step, visible the cycle after rinc.
REQ-015 raddr SHALL load {rgnext[ADDRSIZE]^rgnext[ADDRSIZE-1], rgnext[ADDRSIZE-2:0]}, identical address encoding to the write side, so write and read sides index the same memory entry for equal pointer counts.
REQ-016 rempty SHALL load (rgnext == rq2_wptr) every edge; asserts in the same cycle rptr reaches the synchronized write pointer.
REQ-017 rinc while rempty=1 SHALL be ignored: rptr, raddr, rlevel unchanged.
REQ-018 rlevel SHALL load (bin(rq2_wptr) - rbnext) modulo 2**(ADDRSIZE+1); never exceeds 2**ADDRSIZE for legal write-side operation.
REQ-019 ralmost_empty SHALL load (next rlevel <= AE_THRESH); rempty=1 implies ralmost_empty=1.
REQ-020 Pointer wrap: after 2**(ADDRSIZE+1) reads rptr SHALL return to 0; wrap of the MSB SHALL not disturb rempty or rlevel.
REQ-021 Write-side pointer change SHALL reach rempty/rlevel at the third rclk edge after it is stable (two sync flops + one flag register); this pessimism is intended.
REQ-022 Simultaneous rinc and new write data: read granted per current rempty; rempty reflects both in the next cycle.

Reset
REQ-023 With rrst_n=0 at a rising edge: rq1_wptr=0, rq2_wptr=0, rptr=0, raddr=0, rempty=1, ralmost_empty=1, rlevel=0; rinc ignored.
REQ-024 Reset asserted mid-operation SHALL override any pending read in the same edge; no partial pointer update.
REQ-025 Between rrst_n deassertion and first edge no output changes; no asynchronous reset path exists.

Structure
REQ-026 Shared package fifo_pkg SHALL hold the Gray-to-binary and binary-to-Gray functions and the default ADDRSIZE constant, common with the write-side block.
REQ-027 The synchronizer SHALL be a separate sub-module sync_w2r (parameter ADDRSIZE, ports rclk, rrst_n, wptr, rq2_wptr).

Verification (ADDRSIZE=4, AE_THRESH=2)
REQ-028 Reset 2 cycles with rinc=1 -> rptr=0, raddr=0, rempty=1, ralmost_empty=1, rlevel=0; rptr stays 0 after release while wptr=0.
REQ-029 wptr 0 -> 5'b00001 -> rempty=0, rlevel=1 at third rclk edge; one-cycle rinc -> rptr=5'b00001, rempty=1, rlevel=0 next edge.
REQ-030 wptr held at Gray(16)=5'b11000, rinc=1 continuous -> 16 reads, raddr follows 4-bit Gray 0..15, rlevel 16->0, rempty=1 after the 16th read, further rinc ignored.
REQ-031 Level 3 then one read -> rlevel=2, ralmost_empty=1; level 3 -> ralmost_empty=0.
REQ-032 32 reads with matching wptr steps -> rptr wraps to 5'b00000, rempty and rlevel remain correct across the wrap.
REQ-033 rrst_n=0 while rinc=1 and rlevel=5 -> all outputs at reset values next edge.

Source files
------------

// File: rtl/fifo_pkg.sv
// -----------------------------------------------------------------------------
// fifo_pkg
// Items shared by the read-side and write-side pointer blocks of the
// asynchronous FIFO:
//   ADDRSIZE_DEFAULT : default memory address width (depth = 2**ADDRSIZE)
//   gray2bin()       : Gray code -> binary, for pointers up to 32 bits
//   bin2gray()       : binary -> Gray code, for pointers up to 32 bits
// Narrower pointers are zero-extended into the 32-bit argument. Zero upper
// bits map to zero upper bits in both directions, so the low bits of the
// result are the correct narrow conversion.
// -----------------------------------------------------------------------------
package fifo_pkg;

   localparam int ADDRSIZE_DEFAULT = 4;

   function automatic logic [31:0] gray2bin(input logic [31:0] g);
      logic [31:0] b;
      b[31] = g[31];
      for (int i = 30; i >= 0; i--) begin
         b[i] = b[i+1] ^ g[i];
      end
      return b;
   endfunction

   function automatic logic [31:0] bin2gray(input logic [31:0] b);
      return b ^ (b >> 1);
   endfunction

endpackage : fifo_pkg

// File: rtl/sync_w2r.sv
// -----------------------------------------------------------------------------
// sync_w2r
// Two-flop synchronizer that carries the Gray-coded write pointer into the
// read clock domain. Because the pointer is Gray coded, at most one bit
// changes per write, so a sample taken mid-transition resolves to either
// the old or the new pointer value and never to an unrelated one.
// Ports:
//   rclk     in   read-domain clock
//   rrst_n   in   synchronous active-low reset
//   wptr     in   Gray write pointer (asynchronous to rclk)
//   rq2_wptr out  write pointer after two rclk flops
// -----------------------------------------------------------------------------
module sync_w2r
   import fifo_pkg::*;
#(
   parameter int ADDRSIZE = ADDRSIZE_DEFAULT
) (
   input  logic                rclk,
   input  logic                rrst_n,
   input  logic [ADDRSIZE:0]   wptr,
   output logic [ADDRSIZE:0]   rq2_wptr
);

   logic [ADDRSIZE:0] rq1_wptr_q;
   logic [ADDRSIZE:0] rq2_wptr_q;

   always_ff @(posedge rclk) begin
      if (!rrst_n) begin
         rq1_wptr_q <= '0;
         rq2_wptr_q <= '0;
      end else begin
         rq1_wptr_q <= wptr;
         rq2_wptr_q <= rq1_wptr_q;
      end
   end

   assign rq2_wptr = rq2_wptr_q;

endmodule : sync_w2r

// File: rtl/rptr_empty.sv
// -----------------------------------------------------------------------------
// rptr_empty
// Read-side pointer and status logic of an asynchronous FIFO.
// Ports:
//   rclk          in   read-domain clock
//   rrst_n        in   synchronous active-low reset
//   rinc          in   read request
//   wptr          in   Gray write pointer from the write domain
//   rptr          out  Gray read pointer (to the write domain)
//   raddr         out  memory read address
//   rempty        out  FIFO empty
//   ralmost_empty out  rlevel <= AE_THRESH
//   rlevel        out  entries available to read (0..2**ADDRSIZE)
// Read handshake: rinc is the request and ~rempty is the grant. An entry is
// consumed on a rising rclk edge exactly when rinc=1 and rempty=0 at that
// edge; a request while empty is dropped, not queued.
// The status outputs are computed from the pointer the read side is about
// to hold (rgnext / rbnext), so they agree with rptr in the same cycle.
// -----------------------------------------------------------------------------
module rptr_empty
   import fifo_pkg::*;
#(
   parameter int ADDRSIZE  = ADDRSIZE_DEFAULT,
   parameter int AE_THRESH = 2
) (
   input  logic                rclk,
   input  logic                rrst_n,
   input  logic                rinc,
   input  logic [ADDRSIZE:0]   wptr,
   output logic [ADDRSIZE:0]   rptr,
   output logic [ADDRSIZE-1:0] raddr,
   output logic                rempty,
   output logic                ralmost_empty,
   output logic [ADDRSIZE:0]   rlevel
);

   localparam int PW = ADDRSIZE + 1;
   localparam logic [PW-1:0] AE_TH = PW'(AE_THRESH);

   logic [PW-1:0]       rq2_wptr;

   logic [PW-1:0]       rptr_q,   rptr_d;
   logic [ADDRSIZE-1:0] raddr_q,  raddr_d;
   logic                rempty_q, rempty_d;
   logic                ralmost_q, ralmost_d;
   logic [PW-1:0]       rlevel_q, rlevel_d;

   logic [31:0]         rbin_w;
   logic [31:0]         rgnext_w;
   logic [31:0]         wbin_w;
   logic [PW-1:0]       rbin;
   logic [PW-1:0]       rbnext;
   logic [PW-1:0]       rgnext;
   logic [PW-1:0]       wbin;
   logic                rd_grant;

   sync_w2r #(
      .ADDRSIZE (ADDRSIZE)
   ) u_sync_w2r (
      .rclk     (rclk),
      .rrst_n   (rrst_n),
      .wptr     (wptr),
      .rq2_wptr (rq2_wptr)
   );

   always_comb begin
      rbin_w   = gray2bin({{(32-PW){1'b0}}, rptr_q});
      rbin     = rbin_w[PW-1:0];
      rd_grant = rinc & ~rempty_q;
      // Adding in PW bits gives the required modulo-2**PW wrap for free.
      rbnext   = rbin + {{ADDRSIZE{1'b0}}, rd_grant};
      rgnext_w = bin2gray({{(32-PW){1'b0}}, rbnext});
      rgnext   = rgnext_w[PW-1:0];
      wbin_w   = gray2bin({{(32-PW){1'b0}}, rq2_wptr});
      wbin     = wbin_w[PW-1:0];

      rptr_d    = rgnext;
      // Folding the two Gray MSBs turns the low bits into a plain
      // ADDRSIZE-bit Gray count, matching the write side's address.
      raddr_d   = {rgnext[ADDRSIZE] ^ rgnext[ADDRSIZE-1], rgnext[ADDRSIZE-2:0]};
      rempty_d  = (rgnext == rq2_wptr);
      rlevel_d  = wbin - rbnext;
      ralmost_d = (rlevel_d <= AE_TH);
   end

   always_ff @(posedge rclk) begin
      if (!rrst_n) begin
         rptr_q    <= '0;
         raddr_q   <= '0;
         rempty_q  <= 1'b1;
         ralmost_q <= 1'b1;
         rlevel_q  <= '0;
      end else begin
         rptr_q    <= rptr_d;
         raddr_q   <= raddr_d;
         rempty_q  <= rempty_d;
         ralmost_q <= ralmost_d;
         rlevel_q  <= rlevel_d;
      end
   end

   assign rptr          = rptr_q;
   assign raddr         = raddr_q;
   assign rempty        = rempty_q;
   assign ralmost_empty = ralmost_q;
   assign rlevel        = rlevel_q;

endmodule : rptr_empty

// File: tb/tb_rptr_empty.sv
// -----------------------------------------------------------------------------
// tb_rptr_empty
// Bench for rptr_empty with ADDRSIZE=4, AE_THRESH=2. The reference model
// counts reads and writes as plain integers: the write count the read side
// may act on is the one driven two edges earlier, the level is the
// difference of counts modulo 32, empty means level zero, and the expected
// pointers are Gray codes of the read count.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_rptr_empty;

   localparam int ADDRSIZE  = 4;
   localparam int AE_THRESH = 2;

   logic       rclk;
   logic       rrst_n;
   logic       rinc;
   logic [4:0] wptr;
   logic [4:0] rptr;
   logic [3:0] raddr;
   logic       rempty;
   logic       ralmost_empty;
   logic [4:0] rlevel;

   int n_cmp;
   int n_bad;

   // reference model state
   int wcount;    // total entries written (write-domain view)
   int rd_total;  // total entries read since last reset
   int s1, s2;    // write count (mod 32) as seen 1 and 2 edges ago
   int m_level;
   bit m_empty;

   rptr_empty #(
      .ADDRSIZE  (ADDRSIZE),
      .AE_THRESH (AE_THRESH)
   ) dut (
      .rclk          (rclk),
      .rrst_n        (rrst_n),
      .rinc          (rinc),
      .wptr          (wptr),
      .rptr          (rptr),
      .raddr         (raddr),
      .rempty        (rempty),
      .ralmost_empty (ralmost_empty),
      .rlevel        (rlevel)
   );

   // clock / reset
   initial rclk = 1'b0;
   always #5 rclk = ~rclk;

   function automatic int gray(input int v);
      return v ^ (v >> 1);
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One rclk cycle: drive at negedge, update the model at posedge,
   // compare all outputs 1ns after the edge.
   task automatic step(input bit rst_n_v, input bit rinc_v);
      bit grant;
      int rmod;
      @(negedge rclk);
      rrst_n = rst_n_v;
      rinc   = rinc_v;
      wptr   = 5'(gray(wcount % 32));
      @(posedge rclk);
      if (!rst_n_v) begin
         rd_total = 0;
         s1       = 0;
         s2       = 0;
         m_level  = 0;
         m_empty  = 1'b1;
      end else begin
         grant    = rinc_v && !m_empty;
         rd_total = rd_total + int'(grant);
         rmod     = rd_total % 32;
         m_level  = (s2 - rmod + 32) % 32;
         m_empty  = (m_level == 0);
         s2       = s1;
         s1       = wcount % 32;
      end
      #1;
      chk("rptr",          32'(rptr),          32'(gray(rd_total % 32)));
      chk("raddr",         32'(raddr),         32'(gray(rd_total % 16)));
      chk("rempty",        32'(rempty),        32'(m_empty));
      chk("ralmost_empty", 32'(ralmost_empty), 32'(m_level <= AE_THRESH));
      chk("rlevel",        32'(rlevel),        32'(m_level));
   endtask

   initial begin
      n_cmp    = 0;
      n_bad    = 0;
      wcount   = 0;
      rd_total = 0;
      s1       = 0;
      s2       = 0;
      m_level  = 0;
      m_empty  = 1'b1;
      rrst_n   = 1'b0;
      rinc     = 1'b1;
      wptr     = '0;

      // reset two cycles with rinc held high
      step(1'b0, 1'b1);
      step(1'b0, 1'b1);
      chk("rst_rptr",   32'(rptr),   32'd0);
      chk("rst_rempty", 32'(rempty), 32'd1);
      chk("rst_rlevel", 32'(rlevel), 32'd0);
      // released, wptr still 0: reads must be ignored
      for (int i = 0; i < 3; i++) step(1'b1, 1'b1);
      chk("idle_rptr", 32'(rptr), 32'd0);

      // single write: visible at the third edge
      wcount = 1;
      step(1'b1, 1'b0);
      step(1'b1, 1'b0);
      chk("w1_edge2_rempty", 32'(rempty), 32'd1);
      step(1'b1, 1'b0);
      chk("w1_edge3_rempty", 32'(rempty), 32'd0);
      chk("w1_edge3_rlevel", 32'(rlevel), 32'd1);
      step(1'b1, 1'b1);
      chk("r1_rptr",   32'(rptr),   32'h01);
      chk("r1_rempty", 32'(rempty), 32'd1);
      chk("r1_rlevel", 32'(rlevel), 32'd0);
      step(1'b1, 1'b0);

      // full FIFO (16 entries) drained with continuous rinc
      wcount = 17;
      for (int i = 0; i < 22; i++) step(1'b1, 1'b1);
      chk("burst_rptr",   32'(rptr),   32'h19);
      chk("burst_rempty", 32'(rempty), 32'd1);
      chk("burst_rlevel", 32'(rlevel), 32'd0);

      // almost-empty threshold
      wcount = wcount + 3;
      for (int i = 0; i < 3; i++) step(1'b1, 1'b0);
      chk("lvl3_rlevel", 32'(rlevel),        32'd3);
      chk("lvl3_almost", 32'(ralmost_empty), 32'd0);
      step(1'b1, 1'b1);
      chk("lvl2_rlevel", 32'(rlevel),        32'd2);
      chk("lvl2_almost", 32'(ralmost_empty), 32'd1);

      // random reads/writes over many pointer wraps
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 2) != 0 && (wcount - rd_total) < 16) wcount++;
         step(1'b1, 1'($urandom_range(0, 1)));
      end

      // drain, then reset mid-operation at level 5 with rinc high
      for (int i = 0; i < 64 && (wcount != rd_total || !m_empty); i++) step(1'b1, 1'b1);
      wcount = wcount + 5;
      for (int i = 0; i < 4; i++) step(1'b1, 1'b0);
      chk("pre_rst_rlevel", 32'(rlevel), 32'd5);
      wcount = 0;
      step(1'b0, 1'b1);
      chk("mid_rst_rptr",   32'(rptr),          32'd0);
      chk("mid_rst_raddr",  32'(raddr),         32'd0);
      chk("mid_rst_rempty", 32'(rempty),        32'd1);
      chk("mid_rst_almost", 32'(ralmost_empty), 32'd1);
      chk("mid_rst_rlevel", 32'(rlevel),        32'd0);
      for (int i = 0; i < 3; i++) step(1'b1, 1'b1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule : tb_rptr_empty
